mult16_seq: RTL

- Multi-cycle controller that computes an unsigned 16x16 -> 32-bit product using one shared 8x8 byte multiplier (mult_byte).
- Sequences the four byte partial products through that multiplier and accumulates them with the correct shifts.
- Presents valid/ready handshakes on both sides.
- Sits between the issue logic and the writeback path as the area-cheap multiply unit.

---
 rtl/mult16_seq_pkg.sv | 35 +++
 rtl/mult16_seq_mult_byte.sv | 15 +
 rtl/mult16_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult16_seq_pkg.sv
// Shared constants for the sequential 16x16 multiplier: state encoding,
// step encoding, per-step shift amounts and datapath widths.
package mult16_seq_pkg;

  localparam int OP_W   = 16;
  localparam int BYTE_W = 8;
  localparam int PRD_W  = 32;

  typedef logic [1:0] state_t;
  typedef logic [1:0] step_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam step_t STEP0 = 2'd0;
  localparam step_t STEP1 = 2'd1;
  localparam step_t STEP2 = 2'd2;
  localparam step_t STEP3 = 2'd3;

  // Left shift applied to each byte partial product before accumulation.
  function automatic logic [4:0] step_shift(input step_t step);
    logic [4:0] sh;
    sh = 5'd0;
    case (step)
      STEP0:   sh = 5'd0;
      STEP1:   sh = 5'd8;
      STEP2:   sh = 5'd8;
      STEP3:   sh = 5'd16;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mult16_seq_mult_byte.sv
// Shared 8x8 unsigned byte multiplier, purely combinational.
module mult_byte
  import mult16_seq_pkg::*;
(
  input  logic [BYTE_W-1:0]   a,
  input  logic [BYTE_W-1:0]   b,
  output logic [2*BYTE_W-1:0] p
);

  // Full 16-bit product of two unsigned bytes.
  always_comb begin
    p = (2*BYTE_W)'(a) * (2*BYTE_W)'(b);
  end

endmodule

// File: rtl/mult16_seq.sv
// Area-cheap unsigned 16x16 -> 32 multiplier. The four byte partial
// products are pushed through one shared 8x8 multiplier, one per cycle,
// and summed into a 32-bit accumulator.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; accept latches operands/tag, clears acc
// MUL   | one byte partial product per cycle, step 0..3
// DONE  | result presented, held until out_ready
module mult16_seq
  import mult16_seq_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int ZERO_SKIP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRD_W-1:0] out_prod,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_t              state;
  step_t               step;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [PRD_W-1:0]    acc;

  logic [BYTE_W-1:0]   byte_a;
  logic [BYTE_W-1:0]   byte_b;
  logic [2*BYTE_W-1:0] prd;
  logic [PRD_W-1:0]    partial;
  logic                zero_op;

  // Select the operand bytes for the current step from latched operands only.
  always_comb begin
    byte_a = a_q[7:0];
    byte_b = b_q[7:0];
    case (step)
      STEP0: begin byte_a = a_q[7:0];  byte_b = b_q[7:0];  end
      STEP1: begin byte_a = a_q[7:0];  byte_b = b_q[15:8]; end
      STEP2: begin byte_a = a_q[15:8]; byte_b = b_q[7:0];  end
      STEP3: begin byte_a = a_q[15:8]; byte_b = b_q[15:8]; end
      default: ;
    endcase
  end

  mult_byte u_mult_byte (
    .a (byte_a),
    .b (byte_b),
    .p (prd)
  );

  // Align the byte product; the true product never exceeds 32 bits.
  always_comb begin
    partial = {{(PRD_W-2*BYTE_W){1'b0}}, prd} << step_shift(step);
    zero_op = (ZERO_SKIP != 0) && ((in_a == '0) || (in_b == '0));
  end

  // Controller: FSM, step counter, operand/tag capture and accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      step  <= STEP0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            acc   <= '0;
            step  <= STEP0;
            state <= zero_op ? ST_DONE : ST_MUL;
          end
        end
        ST_MUL: begin
          acc <= acc + partial;
          if (step == STEP3) begin
            step  <= STEP0;
            state <= ST_DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs come straight from registers; no path from in_* to out_*.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_MUL) || (state == ST_DONE);
    out_prod  = acc;
    out_tag   = tag_q;
  end

endmodule
